// File: rtl/seq_ctrl_pkg.sv
// Shared types and default widths for the sequence-generator burst controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/seq_out_stage.sv
// Single-entry valid/ready output register holding one generator term.
// Latency: 1 cycle from load_i to valid_o/data_o.
// Backpressure: holds data_o/valid_o while valid_o & !ready_i; flush_i drops valid.
module seq_out_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  // Flush beats load; an accepted beat with nothing new behind it empties the slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/seq_gen_ctrl.sv
// Burst controller: restarts the generator and streams burst_len terms to a consumer.
// Latency: start at edge k -> gen_clr_o in cycle k+1 -> term0 valid after edge k+2.
// Backpressure: valid_o & !ready_i freezes data_o/valid_o and stops generator advance.
module seq_gen_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [DATA_W-1:0] gen_seq_i,
  output logic              gen_clr_o,
  output logic              gen_adv_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic [LEN_W-1:0]  count_o,
  output logic              done_o,
  output logic              abort_o
);

  state_e             state_d, state_q;
  logic [LEN_W-1:0]   len_d, len_q;
  logic [LEN_W-1:0]   issued_d, issued_q;
  logic [LEN_W-1:0]   count_d, count_q;
  logic               done_d, done_q;
  logic               abort_d, abort_q;
  logic               clr_d, clr_q;
  logic               load;
  logic               flush;
  logic               accept;

  assign accept = valid_o & ready_i;

  // Next-state, counters and pulse generation; stop_i overrides everything while busy.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    count_d  = count_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    clr_d    = 1'b0;
    load     = 1'b0;
    flush    = 1'b0;

    if (accept) count_d = count_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (burst_len_i != '0) begin
            len_d    = burst_len_i;
            issued_d = '0;
            count_d  = '0;
            clr_d    = 1'b1;
            state_d  = CLEAR;
          end else begin
            // Empty burst completes immediately without touching the generator.
            done_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (stop_i) begin
          flush   = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          flush   = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          load = (!valid_o || ready_i) && (issued_q < len_q);
          if (load) begin
            issued_d = issued_q + LEN_W'(1);
            if (issued_d == len_q) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (stop_i) begin
          flush   = 1'b1;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      count_q  <= count_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      clr_q    <= clr_d;
    end
  end

  seq_out_stage #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (ready_i),
    .data_i  (gen_seq_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  // Advance is combinational so the generator steps on the same edge the term is captured.
  assign gen_adv_o = load;
  assign gen_clr_o = clr_q;
  assign busy_o    = (state_q != IDLE);
  assign count_o   = count_q;
  assign done_o    = done_q;
  assign abort_o   = abort_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Scoreboard bench for seq_gen_ctrl with a term n = 3*n generator model.
// Latency: n/a.
// Backpressure: ready_i driven by directed stimulus.
module tb_seq_gen_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [LW-1:0] burst_len_i = '0;
  logic [DW-1:0] gen_seq_i;
  logic          gen_clr_o, gen_adv_o, valid_o, busy_o, done_o, abort_o;
  logic [DW-1:0] data_o;
  logic [LW-1:0] count_o;

  always #5 clk = ~clk;

  seq_gen_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .burst_len_i (burst_len_i),
    .gen_seq_i   (gen_seq_i),
    .gen_clr_o   (gen_clr_o),
    .gen_adv_o   (gen_adv_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .count_o     (count_o),
    .done_o      (done_o),
    .abort_o     (abort_o)
  );

  // Generator model: clear restarts at term 0, advance steps one term.
  logic [DW-1:0] gen_idx;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       gen_idx <= '0;
    else if (gen_clr_o) gen_idx <= '0;
    else if (gen_adv_o) gen_idx <= gen_idx + 32'd1;
  end
  assign gen_seq_i = gen_idx * 32'd3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_cnt, adv_cnt, done_cnt, abort_cnt, busy_cnt, acc_cnt, first_acc, last_acc;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic          prev_stall = 1'b0;
  logic          prev_stop = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr_cnt = 0; adv_cnt = 0; done_cnt = 0; abort_cnt = 0;
    busy_cnt = 0; acc_cnt = 0; first_acc = -1; last_acc = -1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check(name, (done_cnt > 0), 1);
  endtask

  // Monitor: pops expected terms on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    if (reset_n) begin
      if (gen_clr_o) clr_cnt++;
      if (gen_adv_o) adv_cnt++;
      if (done_o)    done_cnt++;
      if (abort_o)   abort_cnt++;
      if (busy_o)    busy_cnt++;
      if (prev_stall && !prev_stop) begin
        check("stall_valid", valid_o, 1);
        check("stall_data", data_o, prev_dat);
      end
      if (valid_o && ready_i) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got data %0d expected no beat", data_o);
        end else begin
          exp_v = exp_q.pop_front();
          check("sb_data", data_o, exp_v);
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_dat   = data_o;
      prev_stop  = stop_i;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_clr"}, gen_clr_o, 0);
    check({tag, "_adv"}, gen_adv_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_abort"}, abort_o, 0);
  endtask

  task automatic push_terms(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(3 * i));
  endtask

  initial begin
    int s;
    int n;
    clear_stats();
    repeat (2) step();
    check_all_zero("rst");
    reset_n = 1'b1;
    step();

    // Full-rate burst of 5.
    clear_stats();
    ready_i = 1'b1; burst_len_i = 16'd5; start_i = 1'b1;
    push_terms(5);
    step();
    start_i = 1'b0;
    s = cyc;
    check("t2_clr_now", gen_clr_o, 1);
    wait_done(30, "t2_done_seen");
    repeat (2) step();
    check("t2_clr_cnt", clr_cnt, 1);
    check("t2_adv_cnt", adv_cnt, 5);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_abort_cnt", abort_cnt, 0);
    check("t2_count", count_o, 5);
    check("t2_first_acc", first_acc, s + 2);
    check("t2_last_acc", last_acc, s + 6);
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_busy", busy_o, 0);

    // Alternating backpressure, burst of 4.
    clear_stats();
    ready_i = 1'b1; burst_len_i = 16'd4; start_i = 1'b1;
    push_terms(4);
    step();
    start_i = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 60) begin
      ready_i = ~ready_i;
      step();
      n++;
    end
    check("t3_done_seen", (done_cnt > 0), 1);
    repeat (2) step();
    check("t3_done_cnt", done_cnt, 1);
    check("t3_count", count_o, 4);
    check("t3_adv_cnt", adv_cnt, 4);
    check("t3_sb_empty", exp_q.size(), 0);

    // Abort during the third accepted beat, then restart.
    clear_stats();
    ready_i = 1'b1; burst_len_i = 16'd8; start_i = 1'b1;
    push_terms(8);
    step();
    start_i = 1'b0;
    n = 0;
    while (acc_cnt < 2 && n < 30) begin
      step();
      n++;
    end
    check("t4_two_acc", acc_cnt, 2);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("t4_abort_now", abort_o, 1);
    check("t4_valid_off", valid_o, 0);
    check("t4_idle", busy_o, 0);
    repeat (3) step();
    check("t4_abort_cnt", abort_cnt, 1);
    check("t4_no_done", done_cnt, 0);
    check("t4_count", count_o, 3);
    exp_q.delete();
    clear_stats();
    burst_len_i = 16'd2; start_i = 1'b1;
    push_terms(2);
    step();
    start_i = 1'b0;
    wait_done(30, "t4b_done_seen");
    repeat (2) step();
    check("t4b_count", count_o, 2);
    check("t4b_sb_empty", exp_q.size(), 0);

    // Zero-length burst.
    clear_stats();
    burst_len_i = 16'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("t5_done_now", done_o, 1);
    check("t5_busy_now", busy_o, 0);
    repeat (3) step();
    check("t5_clr_cnt", clr_cnt, 0);
    check("t5_busy_cnt", busy_cnt, 0);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_adv_cnt", adv_cnt, 0);

    // Starts while busy are ignored.
    clear_stats();
    ready_i = 1'b1; burst_len_i = 16'd3; start_i = 1'b1;
    push_terms(3);
    step();
    burst_len_i = 16'd7;
    step();
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(30, "t6_done_seen");
    repeat (2) step();
    check("t6_adv_cnt", adv_cnt, 3);
    check("t6_clr_cnt", clr_cnt, 1);
    check("t6_count", count_o, 3);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_sb_empty", exp_q.size(), 0);

    // Start together with stop in IDLE starts nothing.
    clear_stats();
    burst_len_i = 16'd4; start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    repeat (3) step();
    check("t6b_busy_cnt", busy_cnt, 0);
    check("t6b_clr_cnt", clr_cnt, 0);
    check("t6b_done_cnt", done_cnt, 0);
    check("t6b_abort_cnt", abort_cnt, 0);
    check("t6b_adv_cnt", adv_cnt, 0);

    // Asynchronous reset in the middle of a burst.
    clear_stats();
    ready_i = 1'b1; burst_len_i = 16'd8; start_i = 1'b1;
    push_terms(8);
    step();
    start_i = 1'b0;
    repeat (4) step();
    check("t1_busy_before", busy_o, 1);
    #2;
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check_all_zero("t1_rst");
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("t1_no_done", done_cnt, 0);
    check("t1_no_abort", abort_cnt, 0);
    check("t1_busy_after", busy_o, 0);
    check("t1_valid_after", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
